// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions: controller state encoding and default data widths.
package uart_pkg;

    localparam int UART_NB_DATA = 8;
    localparam int UART_NB_OP   = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: counts baud ticks while enabled and flags the tick that closes the window.
module frame_timeout #(
    parameter int NB_TIMEOUT    = 16,
    parameter int TIMEOUT_TICKS = 1600
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_expire
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

    logic [NB_TIMEOUT-1:0] cnt_q;
    logic [NB_TIMEOUT-1:0] cnt_d;

    assign o_expire = i_enable && i_tick && (cnt_q == LAST);

    // Held at zero outside the window so every entry starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_enable || o_expire) begin
            cnt_d = '0;
        end else if (i_tick) begin
            cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode from the UART receiver, runs the ALU and launches one transmit;
// opcode byte at cycle N gives o_tx_start at N+2, bytes arriving while busy are dropped.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int NB_DATA       = UART_NB_DATA,
    parameter int NB_OP         = UART_NB_OP,
    parameter int NB_TIMEOUT    = 16,
    parameter int TIMEOUT_TICKS = 1600
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    ctrl_state_t        state_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               err_q;

    logic in_frame;
    logic expire;
    logic timeout;
    logic unused_rx_hi;

    assign in_frame     = (state_q == GET_B) || (state_q == GET_OP);
    // A byte landing on the expiring tick still belongs to the frame.
    assign timeout      = expire && !i_rx_done;
    assign unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OP];

    frame_timeout #(
        .NB_TIMEOUT    (NB_TIMEOUT),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_rx_done),
        .i_enable (in_frame),
        .i_tick   (i_tick),
        .o_expire (expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_rx_done) begin
                        data_a_q <= i_rx_data;
                        state_q  <= GET_B;
                    end
                end
                GET_B: begin
                    if (i_rx_done) begin
                        data_b_q <= i_rx_data;
                        state_q  <= GET_OP;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                GET_OP: begin
                    if (i_rx_done) begin
                        op_q    <= i_rx_data[NB_OP-1:0];
                        state_q <= EXEC;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q == EXEC) || (state_q == WAIT_TX);

endmodule
